// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Fetch stage for the CPU controller. It holds the program counter
//            and builds each 2*DATA_W-bit instruction from two DATA_W-bit ROM
//            reads, high byte first. It presents the opcode and operand address
//            to the controller. It also drives the shared memory address bus:
//            the PC while fetching, and the IR operand address while executing.
// Ports    : clk, rst_n            clock, asynchronous active-low reset
//            ena                   run enable; low restarts the fetch sequence
//            inc_pc, load_pc       PC increment / PC <= ir_addr (JMP)
//            load_ir, rd           instruction byte capture (needs both)
//            halt                  HLT decoded by the controller
//            data_in               ROM/RAM read data
//            opcode, ir_addr       IR fields of the last complete instruction
//            pc_addr, addr         current PC, memory address bus
//            ir_valid, halted      complete instruction held, sticky halt
// Config   : FETCH_HALT_FREEZE_EN  when defined, halted freezes PC, IR and FSM
// Revision : 1.0  initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int DATA_W                 = 8,
  parameter int ADDR_W                 = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              inc_pc,
  input  logic              load_pc,
  input  logic              load_ir,
  input  logic              rd,
  input  logic              halt,
  input  logic [DATA_W-1:0] data_in,
  output logic [2:0]        opcode,
  output logic [ADDR_W-1:0] ir_addr,
  output logic [ADDR_W-1:0] pc_addr,
  output logic [ADDR_W-1:0] addr,
  output logic              ir_valid,
  output logic              halted
);

  localparam int IR_W = 2 * DATA_W;

  localparam logic [1:0] S_HI   = 2'd0;
  localparam logic [1:0] S_LO   = 2'd1;
  localparam logic [1:0] S_EXEC = 2'd2;

  // The 3-bit opcode and the address must tile the instruction exactly.
  generate
    if (ADDR_W != 2 * DATA_W - 3) begin : g_bad_width
      $error("instr_fetch_unit: ADDR_W must equal 2*DATA_W-3");
    end
  endgenerate

  logic [1:0]        r_state;
  logic [1:0]        w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [IR_W-1:0]   r_ir;
  logic [DATA_W-1:0] r_hi;
  logic              r_ir_valid;
  logic              r_halted;
  logic              w_freeze;
  logic              w_rd_strobe;
  logic              w_cap;
  logic              w_pc_ena;

`ifdef FETCH_HALT_FREEZE_EN
  assign w_freeze = r_halted;
`else
  assign w_freeze = 1'b0;
`endif

  assign w_rd_strobe = load_ir & rd;
  assign w_cap       = ena & w_rd_strobe & ~w_freeze;
  assign w_pc_ena    = ena & ~w_freeze;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_HI;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_ir_valid <= (w_state_next == S_EXEC);
    end
  end

  // Next-state logic. S_EXEC goes straight to S_LO because the byte captured
  // there is already the high byte of the next instruction.
  always_comb begin
    w_state_next = r_state;
    if (!ena) begin
      w_state_next = S_HI;
    end else if (w_cap) begin
      case (r_state)
        S_HI:    w_state_next = S_LO;
        S_LO:    w_state_next = S_EXEC;
        S_EXEC:  w_state_next = S_LO;
        default: w_state_next = S_HI;
      endcase
    end
  end

  // Output logic. During a ROM read the bus must carry the PC, even in S_EXEC.
  always_comb begin
    addr = r_pc;
    if ((r_state == S_EXEC) && !w_rd_strobe) begin
      addr = r_ir[ADDR_W-1:0];
    end
  end

  // Datapath: the high-byte latch, the IR and the PC.
  // The IR changes only on the low byte, so opcode and ir_addr stay stable
  // while the next high byte is being fetched.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_ir <= '0;
    end else if (!ena) begin
      r_hi <= '0;
    end else if (w_cap) begin
      if (r_state == S_LO) begin
        r_ir <= {r_hi, data_in};
      end else begin
        r_hi <= data_in;
      end
    end
  end

  // A load_pc that coincides with a low-byte capture sees the old ir_addr.
  // This is inherent, because r_ir updates at the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc <= RESET_PC;
    end else if (w_pc_ena) begin
      if (load_pc) begin
        r_pc <= r_ir[ADDR_W-1:0];
      end else if (inc_pc) begin
        r_pc <= r_pc + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_halted <= 1'b0;
    end else if (!ena) begin
      r_halted <= 1'b0;
    end else if (halt) begin
      r_halted <= 1'b1;
    end
  end

  assign opcode   = r_ir[IR_W-1 -: 3];
  assign ir_addr  = r_ir[ADDR_W-1:0];
  assign pc_addr  = r_pc;
  assign ir_valid = r_ir_valid;
  assign halted   = r_halted;

endmodule
`default_nettype wire
